jk_bank_ctrl: RTL and testbench

Command-driven sequencer for a bank of WIDTH positive-edge JK flip-flops held inside the block. Each JK cell obeys Q+ = (J & ~Q) | (~K & Q). The block decodes bank commands (set, clear, toggle, load, count up/down for N steps) into per-bit J/K drive and applies them on successive clock edges. Other logic sees the bank contents on `q`, and a one-cycle `done` pulse marks completion. It is the layer that lets higher-level logic use the team's JK primitives without driving J/K by hand.

---
 rtl/jk_bank_ctrl_if.sv | 28 ++
 rtl/jk_bank_ctrl.sv | 114 +++++++++++
 tb/tb_jk_bank_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_ctrl_if.sv
// Command channel into the JK bank sequencer: op/data/len qualified by valid/ready.
// Latency: none, wires only.
// Backpressure: slave drives cmd_ready; master holds its command until it sees ready.
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  sequencer idle and able to take a command
//   cmd_op     master->slave  0 NOP,1 SET,2 CLR,3 TOG,4 LOAD,5 CNT_UP,6 CNT_DN,7 NOP
//   cmd_data   master->slave  bit mask (SET/CLR/TOG) or value (LOAD)
//   cmd_len    master->slave  step count for CNT_UP/CNT_DN
interface jk_bank_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_len;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Sequencer turning bank commands into per-bit J/K drive for an internal bank of JK cells.
// Latency: simple op updates q one edge after accept, done one cycle later; counts step once per edge.
// Backpressure: cmd_ready only in IDLE; a command held while busy waits and is taken once.
//   clk, rst        clock and asynchronous active-low reset
//   cmd (slave)     command channel (valid/ready, op, data, len)
//   j, k            J/K drive currently applied to the bank
//   q               bank contents
//   busy, done      not-idle flag and one-cycle completion pulse
module jk_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    jk_bank_ctrl_if.slave     cmd,
    output logic [WIDTH-1:0]  j,
    output logic [WIDTH-1:0]  k,
    output logic [WIDTH-1:0]  q,
    output logic              busy,
    output logic              done
);
    localparam logic [2:0] OP_SET = 3'd1;
    localparam logic [2:0] OP_CLR = 3'd2;
    localparam logic [2:0] OP_TOG = 3'd3;
    localparam logic [2:0] OP_LOAD = 3'd4;
    localparam logic [2:0] OP_UP  = 3'd5;
    localparam logic [2:0] OP_DN  = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, COUNT, DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] rem;
    logic [WIDTH-1:0] up_t, dn_t;
    logic             accept;
    logic             is_cnt;

    assign accept        = cmd.cmd_valid && (state == IDLE);
    assign is_cnt        = (cmd.cmd_op == OP_UP) || (cmd.cmd_op == OP_DN);
    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_cnt) state_nxt = (cmd.cmd_len == '0) ? DONE : COUNT;
                    else        state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = DONE;
            // rem never reaches zero inside COUNT; <= 1 just keeps the exit robust
            COUNT:   if (rem <= CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Toggle masks for a ripple counter: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q[i-1];
            dn_t[i] = dn_t[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        if (state == EXEC) begin
            case (op_r)
                OP_SET:  j = data_r;
                OP_CLR:  k = data_r;
                OP_TOG:  begin j = data_r; k = data_r;  end
                OP_LOAD: begin j = data_r; k = ~data_r; end
                default: ;
            endcase
        end else if (state == COUNT) begin
            if (op_r == OP_DN) begin j = dn_t; k = dn_t; end
            else               begin j = up_t; k = up_t; end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= '0;
            op_r   <= '0;
            data_r <= '0;
            rem    <= '0;
        end else begin
            // JK characteristic; j=k=0 outside EXEC/COUNT so the bank holds
            q <= (j & ~q) | (~k & q);
            if (accept) begin
                op_r   <= cmd.cmd_op;
                data_r <= cmd.cmd_data;
                rem    <= cmd.cmd_len;
            end else if (state == COUNT) begin
                rem <= rem - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Randomised plus directed bench for jk_bank_ctrl against an arithmetic model of the bank.
// Latency: checks every cycle of each command, sampled 1 time unit after the rising edge.
// Backpressure: holds a command across a running count and checks it is taken exactly once.
module tb_jk_bank_ctrl;
    localparam int W  = 4;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] j, k, q;
    logic         busy, done;
    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] mq;

    always #5 clk = ~clk;

    jk_bank_ctrl_if #(.WIDTH(W), .CNT_W(CW)) cif ();

    jk_bank_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd(cif),
        .j(j), .k(k), .q(q), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bank value after one application of op to value qq.
    function automatic logic [W-1:0] nxt(input logic [2:0] op, input logic [W-1:0] d,
                                         input logic [W-1:0] qq);
        case (op)
            3'd1:    return qq | d;
            3'd2:    return qq & ~d;
            3'd3:    return qq ^ d;
            3'd4:    return d;
            3'd5:    return qq + W'(1);
            3'd6:    return qq - W'(1);
            default: return qq;
        endcase
    endfunction

    function automatic logic [W-1:0] ej(input logic [2:0] op, input logic [W-1:0] d);
        return (op == 3'd1 || op == 3'd3 || op == 3'd4) ? d : '0;
    endfunction

    function automatic logic [W-1:0] ek(input logic [2:0] op, input logic [W-1:0] d);
        case (op)
            3'd2, 3'd3: return d;
            3'd4:       return ~d;
            default:    return '0;
        endcase
    endfunction

    task automatic scramble();
        cif.cmd_op   = 3'($urandom);
        cif.cmd_data = W'($urandom);
        cif.cmd_len  = CW'($urandom);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, cif.cmd_ready, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_j"}, j, 0);
        chk({tag, "_k"}, k, 0);
        chk({tag, "_q"}, q, mq);
    endtask

    // Called at the sample point just after the accept edge; ends at the sample after
    // the edge that returns the block to IDLE.
    task automatic follow(input logic [2:0] op, input logic [W-1:0] d, input logic [CW-1:0] len);
        logic [W-1:0] t;
        if (op == 3'd5 || op == 3'd6) begin
            for (int i = 0; i < int'(len); i++) begin
                t = mq ^ nxt(op, d, mq);
                chk("cnt_busy", busy, 1);
                chk("cnt_ready", cif.cmd_ready, 0);
                chk("cnt_done", done, 0);
                chk("cnt_j", j, t);
                chk("cnt_k", k, t);
                chk("cnt_q", q, mq);
                @(posedge clk); #1;
                mq = nxt(op, d, mq);
            end
        end else begin
            chk("exec_busy", busy, 1);
            chk("exec_ready", cif.cmd_ready, 0);
            chk("exec_done", done, 0);
            chk("exec_j", j, ej(op, d));
            chk("exec_k", k, ek(op, d));
            chk("exec_q", q, mq);
            @(posedge clk); #1;
            mq = nxt(op, d, mq);
        end
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 1);
        chk("fin_j", j, 0);
        chk("fin_k", k, 0);
        chk("fin_q", q, mq);
        @(posedge clk); #1;
        check_idle("post");
    endtask

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            if (cif.cmd_ready === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] d, input logic [CW-1:0] len);
        bit ok;
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = d;
        cif.cmd_len   = len;
        wait_ready(ok);
        if (!ok) return;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        scramble();
        follow(op, d, len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst = 1'b0;
        cif.cmd_valid = 1'b0;
        scramble();
        mq = '0;

        // Reset held with random inputs, then released with the bus idle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cif.cmd_valid = 1'($urandom);
            scramble();
            @(posedge clk); #1;
            check_idle("rst");
        end
        @(negedge clk);
        rst = 1'b1;
        cif.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            scramble();
            @(posedge clk); #1;
            check_idle("rel");
        end

        // Simple ops
        issue(3'd4, 4'b1010, 8'd0);
        chk("load_a", q, 4'b1010);
        issue(3'd1, 4'b0101, 8'd0);
        chk("set_5", q, 4'b1111);
        issue(3'd2, 4'b0011, 8'd0);
        chk("clr_3", q, 4'b1100);
        issue(3'd3, 4'b0110, 8'd0);
        chk("tog_6", q, 4'b1010);

        // Counting with wrap, and a zero-length count
        issue(3'd4, 4'hE, 8'd0);
        issue(3'd5, 4'h0, 8'd5);
        chk("up_wrap", q, 4'h3);
        issue(3'd4, 4'h1, 8'd0);
        issue(3'd6, 4'h0, 8'd3);
        chk("dn_wrap", q, 4'hE);
        issue(3'd6, 4'h0, 8'd0);
        chk("dn_len0", q, 4'hE);

        // Reset in the middle of a long count
        issue(3'd4, 4'h0, 8'd0);
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 3'd5;
        cif.cmd_len   = 8'd200;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin @(posedge clk); #1; end
        chk("mid_q7", q, 4'h7);
        chk("mid_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        mq = '0;
        check_idle("abort");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_idle("abort_quiet");
        end
        issue(3'd4, 4'h9, 8'd0);
        chk("after_abort", q, 4'h9);

        // Command held valid across a running count
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 3'd5;
        cif.cmd_data  = '0;
        cif.cmd_len   = 8'd4;
        wait_ready(ok);
        @(posedge clk); #1;
        cif.cmd_op   = 3'd3;
        cif.cmd_data = 4'hF;
        follow(3'd5, 4'h0, 8'd4);
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        follow(3'd3, 4'hF, 8'd0);
        chk("bp_result", q, 4'hD ^ 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle("bp_once");
        end

        // Random commands with random idle gaps
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                scramble();
                @(posedge clk); #1;
                check_idle("gap");
            end
            issue(3'($urandom), W'($urandom), CW'($urandom_range(0, 12)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
